// File: rtl/vga_timing_gen.sv
// Display timing engine: phase-local down-counters per axis drive registered sync/de/position
// outputs, with a valid/ready pixel pull from the frame-buffer fetch path.
module vga_timing_gen #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned RGB_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 hpol_i,
    input  logic                 vpol_i,
    input  logic [CNT_WIDTH-1:0] hvsize_i,
    input  logic [CNT_WIDTH-1:0] hfpsize_i,
    input  logic [CNT_WIDTH-1:0] hsnsize_i,
    input  logic [CNT_WIDTH-1:0] hbpsize_i,
    input  logic [CNT_WIDTH-1:0] vvsize_i,
    input  logic [CNT_WIDTH-1:0] vfpsize_i,
    input  logic [CNT_WIDTH-1:0] vsnsize_i,
    input  logic [CNT_WIDTH-1:0] vbpsize_i,
    input  logic                 pix_valid_i,
    input  logic [RGB_WIDTH-1:0] pix_data_i,
    output logic                 pix_ready_o,
    input  logic                 underrun_clr_i,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic [RGB_WIDTH-1:0] rgb_o,
    output logic [CNT_WIDTH-1:0] hpos_o,
    output logic [CNT_WIDTH-1:0] vpos_o,
    output logic                 fstart_o,
    output logic                 underrun_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {PhAct, PhFp, PhSn, PhBp} phase_e;

    localparam logic [CNT_WIDTH-1:0] One = CNT_WIDTH'(1);

    state_e state_q, state_d;
    phase_e hph_q, hph_d, vph_q, vph_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_WIDTH-1:0] hv_q, hv_d, hfp_q, hfp_d, hsn_q, hsn_d, hbp_q, hbp_d;
    logic [CNT_WIDTH-1:0] vv_q, vv_d, vfp_q, vfp_d, vsn_q, vsn_d, vbp_q, vbp_d;

    logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic                 fstart_q, fstart_d, underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0] hpos_q, hpos_d, vpos_q, vpos_d;

    phase_e               hnxt, vnxt;
    logic [CNT_WIDTH-1:0] hload, vload;
    logic                 cfg_ok, load_frame, go_idle, active;

    // Following phase with a non-zero size (wrapping to ACT) and its down-counter preload.
    function automatic void next_phase(
        input  phase_e               cur,
        input  logic [CNT_WIDTH-1:0] act,
        input  logic [CNT_WIDTH-1:0] fp,
        input  logic [CNT_WIDTH-1:0] sn,
        input  logic [CNT_WIDTH-1:0] bp,
        output phase_e               nxt,
        output logic [CNT_WIDTH-1:0] load
    );
        nxt  = PhAct;
        load = act - One;
        if (cur != PhBp && bp != '0) begin
            nxt  = PhBp;
            load = bp - One;
        end
        if ((cur == PhAct || cur == PhFp) && sn != '0) begin
            nxt  = PhSn;
            load = sn - One;
        end
        if (cur == PhAct && fp != '0) begin
            nxt  = PhFp;
            load = fp - One;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        hph_d      = hph_q;
        vph_d      = vph_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        hv_d       = hv_q;
        hfp_d      = hfp_q;
        hsn_d      = hsn_q;
        hbp_d      = hbp_q;
        vv_d       = vv_q;
        vfp_d      = vfp_q;
        vsn_d      = vsn_q;
        vbp_d      = vbp_q;
        load_frame = 1'b0;
        go_idle    = 1'b0;
        hnxt       = PhAct;
        vnxt       = PhAct;
        hload      = '0;
        vload      = '0;
        cfg_ok     = (hvsize_i != '0) && (vvsize_i != '0);

        next_phase(hph_q, hv_q, hfp_q, hsn_q, hbp_q, hnxt, hload);
        next_phase(vph_q, vv_q, vfp_q, vsn_q, vbp_q, vnxt, vload);

        unique case (state_q)
            StIdle: load_frame = en_i && cfg_ok;
            StRun: begin
                if (!en_i) begin
                    go_idle = 1'b1;
                end else if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - One;
                end else begin
                    hph_d  = hnxt;
                    hcnt_d = hload;
                    // Wrapping back to ACT marks the end of a line.
                    if (hnxt == PhAct) begin
                        if (vcnt_q != '0) begin
                            vcnt_d = vcnt_q - One;
                        end else if (vnxt != PhAct) begin
                            vph_d  = vnxt;
                            vcnt_d = vload;
                        end else if (cfg_ok) begin
                            load_frame = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (load_frame) begin
            state_d = StRun;
            hph_d   = PhAct;
            vph_d   = PhAct;
            hcnt_d  = hvsize_i - One;
            vcnt_d  = vvsize_i - One;
            hv_d    = hvsize_i;
            hfp_d   = hfpsize_i;
            hsn_d   = hsnsize_i;
            hbp_d   = hbpsize_i;
            vv_d    = vvsize_i;
            vfp_d   = vfpsize_i;
            vsn_d   = vsnsize_i;
            vbp_d   = vbpsize_i;
        end
        if (go_idle) begin
            state_d = StIdle;
            hph_d   = PhAct;
            vph_d   = PhAct;
            hcnt_d  = '0;
            vcnt_d  = '0;
        end
    end

    // Outputs are a registered image of the current counter state.
    always_comb begin
        active     = (state_q == StRun) && en_i;
        de_d       = active && (hph_q == PhAct) && (vph_q == PhAct);
        hsync_d    = (active && hph_q == PhSn) ? hpol_i : ~hpol_i;
        vsync_d    = (active && vph_q == PhSn) ? vpol_i : ~vpol_i;
        hpos_d     = de_d ? (hv_q - One - hcnt_q) : '0;
        vpos_d     = (active && vph_q == PhAct) ? (vv_q - One - vcnt_q) : '0;
        fstart_d   = de_d && (hcnt_q == hv_q - One) && (vcnt_q == vv_q - One);
        underrun_d = underrun_q;
        if (de_q && !pix_valid_i) begin
            underrun_d = 1'b1;
        end else if (underrun_clr_i) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            hph_q      <= PhAct;
            vph_q      <= PhAct;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            hv_q       <= '0;
            hfp_q      <= '0;
            hsn_q      <= '0;
            hbp_q      <= '0;
            vv_q       <= '0;
            vfp_q      <= '0;
            vsn_q      <= '0;
            vbp_q      <= '0;
            hsync_q    <= ~hpol_i;
            vsync_q    <= ~vpol_i;
            de_q       <= 1'b0;
            hpos_q     <= '0;
            vpos_q     <= '0;
            fstart_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hph_q      <= hph_d;
            vph_q      <= vph_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            hv_q       <= hv_d;
            hfp_q      <= hfp_d;
            hsn_q      <= hsn_d;
            hbp_q      <= hbp_d;
            vv_q       <= vv_d;
            vfp_q      <= vfp_d;
            vsn_q      <= vsn_d;
            vbp_q      <= vbp_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            fstart_q   <= fstart_d;
            underrun_q <= underrun_d;
        end
    end

    // The pixel is taken in the same cycle ready is shown, so rgb follows the live input.
    assign pix_ready_o = de_q;
    assign rgb_o       = (de_q && pix_valid_i) ? pix_data_i : '0;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;
    assign hpos_o      = hpos_q;
    assign vpos_o      = vpos_q;
    assign fstart_o    = fstart_q;
    assign underrun_o  = underrun_q;

endmodule
